// File: rtl/fill_sequencer.sv
// Scanline fill sequencer: one edge-math pass, then walks rows y_start..y_end in either
// direction, handshaking the row-scan and (optionally) fill units once per row.
module fill_sequencer #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_en,
  input  logic               outline_only,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] y_end,
  input  logic               abort,
  input  logic               math_done,
  input  logic               row_done,
  input  logic               fill_done,
  output logic               math_start,
  output logic               row_start,
  output logic               fill_start,
  output logic [COORD_W-1:0] cur_row,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MATH,
    S_MATH_WAIT,
    S_ROW,
    S_ROW_WAIT,
    S_FILL,
    S_FILL_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  // Counter value in the last permitted wait cycle; the increment out of it reaches TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

  state_t             state;
  state_t             state_d;
  logic [COORD_W-1:0] y_end_q;
  logic               outline_q;
  logic               dir_up;
  logic [TO_W-1:0]    to_cnt;
  logic               to_hit;

  assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (fill_en) state_d = S_MATH;
      S_MATH:      state_d = S_MATH_WAIT;
      S_MATH_WAIT: begin
        if (math_done)   state_d = S_ROW;
        else if (to_hit) state_d = S_ERR;
      end
      S_ROW:       state_d = S_ROW_WAIT;
      S_ROW_WAIT: begin
        if (row_done)    state_d = outline_q ? S_NEXT : S_FILL;
        else if (to_hit) state_d = S_ERR;
      end
      S_FILL:      state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (fill_done)   state_d = S_NEXT;
        else if (to_hit) state_d = S_ERR;
      end
      S_NEXT:      state_d = (cur_row == y_end_q) ? S_DONE : S_ROW;
      S_DONE:      state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_d = S_IDLE;
  end

  // Outputs are registered from the next state so they align with the state they belong to.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      cur_row    <= '0;
      y_end_q    <= '0;
      outline_q  <= 1'b0;
      dir_up     <= 1'b0;
      to_cnt     <= '0;
      err        <= 1'b0;
      math_start <= 1'b0;
      row_start  <= 1'b0;
      fill_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      math_start <= (state_d == S_MATH);
      row_start  <= (state_d == S_ROW);
      fill_start <= (state_d == S_FILL);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE) || (state_d == S_ERR);
      if (state_d == S_ERR) err <= 1'b1;

      if (state inside {S_MATH_WAIT, S_ROW_WAIT, S_FILL_WAIT}) to_cnt <= to_cnt + 1'b1;
      else                                                     to_cnt <= '0;

      case (state)
        S_IDLE: begin
          if (fill_en) begin
            y_end_q   <= y_end;
            outline_q <= outline_only;
            dir_up    <= (y_end > y_start);
            cur_row   <= y_start;
            err       <= 1'b0;
          end
        end
        S_NEXT: begin
          if (state_d == S_ROW) cur_row <= dir_up ? cur_row + 1'b1 : cur_row - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer: responders return each done a set number of cycles
// after its start pulse; expected counts, row sequences and cycle indices are hand-computed.
module tb_fill_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       fill_en, outline_only, abort;
  logic [9:0] y_start, y_end;
  logic       math_done, row_done, fill_done;
  logic       math_start, row_start, fill_start;
  logic [9:0] cur_row;
  logic       busy, done, err;

  fill_sequencer #(.COORD_W(10), .TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .n_rst(n_rst), .fill_en(fill_en), .outline_only(outline_only),
    .y_start(y_start), .y_end(y_end), .abort(abort),
    .math_done(math_done), .row_done(row_done), .fill_done(fill_done),
    .math_start(math_start), .row_start(row_start), .fill_start(fill_start),
    .cur_row(cur_row), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_math, n_row, n_fill, n_done, cyc, done_cyc;
  int lat_math = 1, lat_row = 1, lat_fill = 1;
  int m_cnt, r_cnt, f_cnt;
  logic acc_err, acc_ms;
  bit blk_en = 0;
  logic [9:0] blk_row = '0;
  logic [9:0] rows[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_math = 0; n_row = 0; n_fill = 0; n_done = 0; cyc = 0; done_cyc = 0;
    m_cnt = 0; r_cnt = 0; f_cnt = 0;
    rows.delete();
  endtask

  // One clock: sample outputs 1 time unit after the edge and drive the done responses.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    math_done = 1'b0; row_done = 1'b0; fill_done = 1'b0;
    if (m_cnt != 0) begin m_cnt--; math_done = (m_cnt == 0); end
    if (r_cnt != 0) begin r_cnt--; row_done  = (r_cnt == 0); end
    if (f_cnt != 0) begin f_cnt--; fill_done = (f_cnt == 0); end
    if (math_start) begin n_math++; m_cnt = lat_math; end
    if (row_start)  begin n_row++; rows.push_back(cur_row); r_cnt = lat_row; end
    if (fill_start) begin n_fill++; f_cnt = (blk_en && cur_row == blk_row) ? 0 : lat_fill; end
    if (done) begin n_done++; if (done_cyc == 0) done_cyc = cyc; end
  endtask

  task automatic run_op(input logic [9:0] ys, input logic [9:0] ye, input logic ol, input int budget);
    clear_stats();
    y_start = ys; y_end = ye; outline_only = ol; fill_en = 1'b1;
    step();
    acc_err = err; acc_ms = math_start;
    fill_en = 1'b0; y_start = '0; y_end = '0; outline_only = ~ol;
    for (int i = 0; i < budget && done_cyc == 0; i++) step();
    step();
  endtask

  task automatic chk_rows(input string tag, input int first, input int n, input int dir);
    chk({tag, "_nrows"}, rows.size(), n);
    for (int i = 0; i < n && i < rows.size(); i++) chk({tag, "_row"}, rows[i], first + dir * i);
  endtask

  initial begin
    n_rst = 1'b0; fill_en = 1'b0; outline_only = 1'b0; abort = 1'b0;
    y_start = '0; y_end = '0; math_done = 1'b0; row_done = 1'b0; fill_done = 1'b0;
    clear_stats();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_row", cur_row, 0);
    chk("rst_starts", {math_start, row_start, fill_start}, 0);
    @(posedge clk); #1 n_rst = 1'b1;

    // Solid fill 3..6
    run_op(10'd3, 10'd6, 1'b0, 100);
    chk("t1_done_seen", done_cyc != 0, 1);
    chk("t1_math", n_math, 1);
    chk("t1_row", n_row, 4);
    chk("t1_fill", n_fill, 4);
    chk_rows("t1", 3, 4, 1);
    chk("t1_ndone", n_done, 1);
    chk("t1_latency", done_cyc, 23);
    chk("t1_err", err, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_cur_row_end", cur_row, 6);

    // Outline-only, descending 6..3
    run_op(10'd6, 10'd3, 1'b1, 100);
    chk("t2_row", n_row, 4);
    chk("t2_fill", n_fill, 0);
    chk_rows("t2", 6, 4, -1);
    chk("t2_ndone", n_done, 1);
    chk("t2_latency", done_cyc, 15);
    chk("t2_cur_row_end", cur_row, 3);

    // Single row at the top coordinate
    run_op(10'h3FF, 10'h3FF, 1'b0, 100);
    chk("t3_row", n_row, 1);
    chk_rows("t3", 'h3FF, 1, 0);
    chk("t3_fill", n_fill, 1);
    chk("t3_ndone", n_done, 1);
    chk("t3_latency", done_cyc, 8);
    chk("t3_cur_row_end", cur_row, 'h3FF);

    // fill_done withheld on the second row -> timeout after 4 FILL_WAIT cycles
    blk_en = 1; blk_row = 10'd1;
    run_op(10'd0, 10'd3, 1'b0, 100);
    chk("t4_err", err, 1);
    chk("t4_done_cyc", done_cyc, 15);
    chk("t4_ndone", n_done, 1);
    chk("t4_row", n_row, 2);
    chk("t4_fill", n_fill, 2);
    chk("t4_busy_end", busy, 0);
    step(); step();
    chk("t4_err_sticky", err, 1);
    blk_en = 0;

    // fill_done one cycle too late -> timeout; err cleared on accept first
    lat_fill = 5;
    run_op(10'd7, 10'd7, 1'b0, 100);
    chk("t4c_acc_err_clr", acc_err, 0);
    chk("t4c_err", err, 1);
    chk("t4c_done_cyc", done_cyc, 10);

    // fill_done in the same cycle the counter reaches TIMEOUT -> done wins
    lat_fill = 4;
    run_op(10'd7, 10'd7, 1'b0, 100);
    chk("t4b_acc_err_clr", acc_err, 0);
    chk("t4b_err", err, 0);
    chk("t4b_done_cyc", done_cyc, 11);
    chk("t4b_fill", n_fill, 1);
    lat_fill = 1;

    // Abort in ROW_WAIT on the first row, coinciding with row_done
    clear_stats();
    y_start = 10'd2; y_end = 10'd5; outline_only = 1'b0; fill_en = 1'b1;
    step();
    fill_en = 1'b0;
    for (int i = 0; i < 20 && n_row == 0; i++) step();
    chk("t5_row_seen", n_row, 1);
    step();
    chk("t5_in_row_wait_done", row_done, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_starts", {math_start, row_start, fill_start}, 0);
    step();
    chk("t5_ndone", n_done, 0);
    chk("t5_fill", n_fill, 0);
    chk("t5_err", err, 0);
    run_op(10'd4, 10'd4, 1'b0, 100);
    chk("t5_reaccept_ms", acc_ms, 1);
    chk("t5_reaccept_ndone", n_done, 1);
    chk("t5_reaccept_latency", done_cyc, 8);

    // Asynchronous reset while in FILL, then stray dones while IDLE
    clear_stats();
    y_start = 10'd0; y_end = 10'd2; outline_only = 1'b0; fill_en = 1'b1;
    step();
    fill_en = 1'b0;
    for (int i = 0; i < 20 && n_fill == 0; i++) step();
    chk("t6_fill_seen", fill_start, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_fill_start", fill_start, 0);
    chk("t6_cur_row", cur_row, 0);
    chk("t6_done", done, 0);
    @(posedge clk); #1 n_rst = 1'b1;
    clear_stats();
    math_done = 1'b1; row_done = 1'b1; fill_done = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_starts", {math_start, row_start, fill_start}, 0);
    chk("t6_idle_done", done, 0);
    math_done = 1'b0; row_done = 1'b0; fill_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fill_sequencer.md
Name: fill_sequencer

Overview:
Parametrised scanline fill sequencer for the 2D GPU fill path, the next generation of the fill controller. It runs one edge-math pass, then walks rows from y_start to y_end in either direction, handshaking the row-scan and fill units once per row. It adds an outline-only mode, per-handshake timeout with error reporting, and abort. The block sits between the command decoder (fill_en, coordinates) and the math, row and fill datapath units.

Parameters:
COORD_W, 10, width of row coordinates (y_start, y_end, cur_row)
TIMEOUT, 255, maximum cycles spent in any *_WAIT state before error; 0 disables the timeout
TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
fill_en  in  1  start request; sampled only in IDLE
outline_only  in  1  1 = skip the fill handshake on every row; latched at start
y_start  in  COORD_W  first row; latched at start
y_end  in  COORD_W  last row, inclusive; latched at start
abort  in  1  cancel the current operation
math_done  in  1  edge-math complete pulse
row_done  in  1  row-scan complete pulse
fill_done  in  1  row fill complete pulse
math_start  out  1  one-cycle start pulse to the math unit
row_start  out  1  one-cycle start pulse to the row unit
fill_start  out  1  one-cycle start pulse to the fill unit
cur_row  out  COORD_W  row currently being processed
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky timeout flag; cleared on the next accepted fill_en

Behaviour:
- Reset, or n_rst low at any time including mid-operation: state = IDLE; cur_row, err and the timeout counter = 0; all start pulses, busy and done = 0.
- Moore FSM. States: IDLE, MATH, MATH_WAIT, ROW, ROW_WAIT, FILL, FILL_WAIT, NEXT, DONE, ERR. Outputs decode from the registered state.
- IDLE: when fill_en = 1, latch y_start, y_end and outline_only; set cur_row = y_start; clear err; go to MATH. A fill_en in any other state is ignored.
- MATH: math_start = 1 for exactly this cycle; go to MATH_WAIT.
- MATH_WAIT: on math_done, go to ROW.
- ROW: row_start = 1 for one cycle; go to ROW_WAIT.
- ROW_WAIT: on row_done, go to NEXT if outline_only is set, otherwise go to FILL.
- FILL: fill_start = 1 for one cycle; go to FILL_WAIT.
- FILL_WAIT: on fill_done, go to NEXT.
- NEXT: if cur_row == y_end, go to DONE. Otherwise step cur_row (+1 if y_end > y_start, -1 if y_end < y_start) and go to ROW.
- DONE: done = 1 for one cycle; go to IDLE. cur_row holds its final value.
- Row count is |y_end - y_start| + 1; y_start == y_end processes exactly one row. Direction is fixed at latch time, so cur_row never wraps.
- Done inputs are sampled only in the matching *_WAIT state. A done that coincides with a start cycle, or arrives in any other state, is ignored.
- Timeout: the counter clears on entry to each *_WAIT state and increments every cycle in it. If TIMEOUT != 0 and the counter reaches TIMEOUT without the matching done, go to ERR.
- ERR: err = 1 (sticky); done = 1 for one cycle; go to IDLE.
- Done arriving in the same cycle the counter reaches TIMEOUT: the done wins and no error is raised.
- abort = 1 in any non-IDLE state: next state is IDLE, no done pulse, err unchanged. abort outranks every other transition, including the done/timeout transitions.
- Latency for an N-row solid fill with all done inputs returned one cycle after their start pulse: 2 + 5N + 1 cycles from fill_en to the done pulse, inclusive.

Test Plan:
1. y_start=3, y_end=6, outline_only=0, dones returned 1 cycle after each start -> 1 math_start, 4 row_start, 4 fill_start; cur_row sequence 3,4,5,6; single done pulse; err=0.
2. y_start=6, y_end=3, outline_only=1 -> cur_row 6,5,4,3; fill_start never asserted; 4 row_start pulses; done pulse.
3. y_start=y_end=0x3FF -> exactly one row processed; no wrap to 0; done pulse.
4. TIMEOUT=4, fill_done withheld on row 2 -> ERR entered after 4 cycles in FILL_WAIT; err=1 and done pulse; next fill_en clears err.
5. abort asserted in ROW_WAIT on row 1 -> IDLE next cycle; no done pulse; all starts low; a new fill_en is accepted immediately.
6. n_rst pulsed low in FILL -> all outputs 0 asynchronously; row_done or fill_done arriving while IDLE is ignored.
